ps2_host_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. ED set-LEDs, FF reset) to
//  the keyboard over the open-drain PS2_CLK/PS2_DAT lines, using the device-generated clock.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame constants, parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        ACK,
        WAITIDLE
    } tx_state_t;

    localparam int   FRAME_BITS = 10;
    localparam logic PS2_STOP   = 1'b1;
    localparam logic PS2_START  = 1'b0;

    // Odd parity bit: makes the total count of ones over data+parity odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one open-drain PS/2 line.
// Flops reset to 1 because an idle, pulled-up line reads high.
module ps2_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronize the pad and keep one cycle of history for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter. Inhibits the bus, issues the start
// bit, then shifts the frame out on device clock falls and checks the ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       send,
    input  logic [7:0] data_in,
    output logic       ready,
    output logic       done,
    output logic       error,
    inout  wire        PS2_CLK,
    inout  wire        PS2_DAT
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_nx;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nx;
    logic [3:0]            r_bitcnt;
    logic [3:0]            w_bitcnt_nx;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_clk_oe;
    logic                  w_clk_oe_nx;
    logic                  r_dat_oe;
    logic                  w_dat_oe_nx;
    logic                  r_done;
    logic                  w_done_nx;
    logic                  r_error;
    logic                  w_error_nx;
    logic                  w_load;
    logic                  w_shift_en;

    logic                  w_clk_level;
    logic                  w_clk_fall;
    logic                  w_dat_level;
    logic                  w_dat_fall_unused;

    ps2_line_sync u_clk_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (Resetn),
        .i_line  (PS2_CLK),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_sync u_dat_sync (
        .i_clk   (CLOCK_50),
        .i_rst_n (Resetn),
        .i_line  (PS2_DAT),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall_unused)
    );

    // Open-drain drivers: pull low or float, never drive high.
    assign PS2_CLK = r_clk_oe ? 1'b0 : 1'bz;
    assign PS2_DAT = r_dat_oe ? 1'b0 : 1'bz;

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign error = r_error;

    // Control registers; async reset floats both lines and returns to IDLE at once.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_bitcnt <= w_bitcnt_nx;
            r_clk_oe <= w_clk_oe_nx;
            r_dat_oe <= w_dat_oe_nx;
            r_done   <= w_done_nx;
            r_error  <= w_error_nx;
        end
    end

    // Frame shift register: loaded on accept, shifted LSB-first on each device clock fall.
    always_ff @(posedge CLOCK_50) begin
        if (w_load) begin
            r_shift <= {PS2_STOP, odd_parity(data_in), data_in};
        end else if (w_shift_en) begin
            r_shift <= {PS2_STOP, r_shift[FRAME_BITS-1:1]};
        end
    end

    // Next-state logic; the cycle counter doubles as inhibit timer and device-clock watchdog.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_bitcnt_nx = r_bitcnt;
        w_clk_oe_nx = r_clk_oe;
        w_dat_oe_nx = r_dat_oe;
        w_done_nx   = 1'b0;
        w_error_nx  = 1'b0;
        w_load      = 1'b0;
        w_shift_en  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                if (send) begin
                    w_load      = 1'b1;
                    w_cnt_nx    = '0;
                    w_bitcnt_nx = '0;
                    w_clk_oe_nx = 1'b1;
                    w_state_nx  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (r_cnt == INH_LAST) begin
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = ~PS2_START;
                    w_cnt_nx    = '0;
                    w_state_nx  = RELEASE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (w_clk_fall) begin
                    w_dat_oe_nx = ~r_shift[0];
                    w_shift_en  = 1'b1;
                    w_bitcnt_nx = r_bitcnt + 1'b1;
                    w_cnt_nx    = '0;
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_nx = ACK;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_error_nx  = 1'b1;
                    w_state_nx  = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    w_cnt_nx = '0;
                    if (!w_dat_level) begin
                        w_state_nx = WAITIDLE;
                    end else begin
                        w_dat_oe_nx = 1'b0;
                        w_error_nx  = 1'b1;
                        w_state_nx  = IDLE;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_error_nx  = 1'b1;
                    w_state_nx  = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            WAITIDLE: begin
                if (w_clk_level && w_dat_level) begin
                    w_done_nx  = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_clk_fall) begin
                    w_cnt_nx = '0;
                end else if (r_cnt == TMO_LAST) begin
                    w_clk_oe_nx = 1'b0;
                    w_dat_oe_nx = 1'b0;
                    w_error_nx  = 1'b1;
                    w_state_nx  = IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: begin
                w_clk_oe_nx = 1'b0;
                w_dat_oe_nx = 1'b0;
                w_state_nx  = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks the frame in, a
// scoreboard queue holds the expected done/error outcome of each request.
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int TMO = 2000;

    typedef struct {
        bit          is_done;
        bit          chk_frame;
        logic [10:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready;
    logic       done;
    logic       error;
    wire        ps2_clk;
    wire        ps2_dat;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [10:0] dev_frame = '1;
    exp_t        sb_q[$];

    pullup (ps2_clk);
    pullup (ps2_dat);
    assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
    assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLOCK_50 (clk),
        .Resetn   (rstn),
        .send     (send),
        .data_in  (din),
        .ready    (ready),
        .done     (done),
        .error    (error),
        .PS2_CLK  (ps2_clk),
        .PS2_DAT  (ps2_dat)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done/error pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rstn && (done || error)) begin
            chk("pulse_exclusive", 32'(done & error), 32'd0);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("pulse_is_done", 32'(done), 32'(e.is_done));
                chk("pulse_is_error", 32'(error), 32'(!e.is_done));
                if (e.chk_frame) chk("device_frame", 32'(dev_frame), 32'(e.frame));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_send(input logic [7:0] b);
        @(negedge clk);
        send = 1'b1;
        din  = b;
        @(negedge clk);
        send = 1'b0;
        din  = 8'h00;
    endtask

    // Device model: measures inhibit, samples DAT on each clock rise, optional ACK on clock 11.
    task automatic dev_run(input int nclk, input bit ack, output int inh_len);
        int n;
        int t0;
        logic [10:0] rx;
        rx = '1;
        n = 0;
        while (ps2_clk !== 1'b0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        n = 0;
        while (ps2_clk !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        inh_len = cyc - t0;
        rx[0] = ps2_dat;
        for (int k = 1; k <= nclk; k++) begin
            repeat (30) @(negedge clk);
            if (k == 11 && ack) dev_dat_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (40) @(negedge clk);
            dev_clk_low = 1'b0;
            #1;
            if (k <= 10) rx[k] = ps2_dat;
            if (k == 10) dev_frame = rx;
        end
        if (nclk >= 11) begin
            repeat (5) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic wait_sb(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(sb_q.size()), 32'd0);
    endtask

    // Directed vectors: byte and its hand-computed odd parity bit.
    logic [7:0] vec_byte [3] = '{8'hED, 8'hFF, 8'h07};
    logic       vec_par  [3] = '{1'b1, 1'b1, 1'b0};

    initial begin
        int   inh;
        int   t_rel;
        int   n;
        exp_t e;

        // Reset state
        #5;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_clk_pin", 32'(ps2_clk), 32'd1);
        chk("rst_dat_pin", 32'(ps2_dat), 32'd1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Normal frames with ACK
        for (int i = 0; i < 3; i++) begin
            e.is_done   = 1'b1;
            e.chk_frame = 1'b1;
            e.frame     = {1'b1, vec_par[i], vec_byte[i], 1'b0};
            sb_q.push_back(e);
            do_send(vec_byte[i]);
            chk("busy_after_accept", 32'(ready), 32'd0);
            dev_run(11, 1'b1, inh);
            chk("inhibit_cycles", 32'(inh), 32'(INH));
            wait_sb("frame_complete");
            @(negedge clk);
            chk("ready_after_done", 32'(ready), 32'd1);
            repeat (10) @(negedge clk);
        end

        // NACK: device leaves DAT high on clock 11
        e.is_done   = 1'b0;
        e.chk_frame = 1'b1;
        e.frame     = {1'b1, 1'b1, 8'h81, 1'b0};
        sb_q.push_back(e);
        do_send(8'h81);
        dev_run(11, 1'b0, inh);
        wait_sb("nack_complete");
        chk("ready_after_nack", 32'(ready), 32'd1);
        repeat (10) @(negedge clk);

        // Timeout: device never clocks after release
        e.is_done   = 1'b0;
        e.chk_frame = 1'b0;
        e.frame     = '0;
        sb_q.push_back(e);
        do_send(8'h3C);
        dev_run(0, 1'b0, inh);
        t_rel = cyc;
        n = 0;
        while (error !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 32'(cyc - t_rel), 32'(TMO));
        chk("timeout_clk_pin", 32'(ps2_clk), 32'd1);
        chk("timeout_dat_pin", 32'(ps2_dat), 32'd1);
        chk("timeout_ready", 32'(ready), 32'd1);
        wait_sb("timeout_complete");
        repeat (10) @(negedge clk);

        // send while busy is ignored; the frame in flight keeps the first byte
        e.is_done   = 1'b1;
        e.chk_frame = 1'b1;
        e.frame     = {1'b1, 1'b1, 8'hA5, 1'b0};
        sb_q.push_back(e);
        do_send(8'hA5);
        fork
            dev_run(11, 1'b1, inh);
            begin
                repeat (300) @(negedge clk);
                send = 1'b1;
                din  = 8'h12;
                @(negedge clk);
                send = 1'b0;
                din  = 8'h00;
            end
        join
        wait_sb("busy_frame_complete");
        repeat (200) @(negedge clk);
        chk("busy_no_second_frame", 32'(ready), 32'd1);

        // Reset mid-RELEASE after 4 bits (d3 of 8'h00 holds DAT low)
        do_send(8'h00);
        dev_run(4, 1'b0, inh);
        chk("dat_low_before_reset", 32'(ps2_dat), 32'd0);
        chk("busy_before_reset", 32'(ready), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrst_clk_pin", 32'(ps2_clk), 32'd1);
        chk("midrst_dat_pin", 32'(ps2_dat), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_error", 32'(error), 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (100) @(negedge clk);
        chk("post_reset_ready", 32'(ready), 32'd1);
        chk("post_reset_queue", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
